// File: rtl/param_ram_pkg.sv
// Shared definitions for the parameterised RAM: default geometry and the
// controller state encoding.
package param_ram_pkg;

    localparam int DEF_ADDR_BITS = 8;
    localparam int DEF_DATA_BITS = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

endpackage

// File: rtl/param_ram_byte_merge.sv
// Combinational byte-enable merge: bytes with be=1 come from new_word,
// all others keep old_word.
module byte_merge
    import param_ram_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic [DATA_BITS-1:0]   old_word,
    input  logic [DATA_BITS-1:0]   new_word,
    input  logic [DATA_BITS/8-1:0] be,
    output logic [DATA_BITS-1:0]   merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < DATA_BITS / 8; i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/param_ram.sv
// Single-clock RAM with byte-enable writes, registered reads, optional
// write-first forwarding and a zeroing sweep after reset or on clear.
module param_ram
    import param_ram_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int BYPASS    = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   clear,
    output logic                   busy,
    input  logic                   we,
    input  logic [DATA_BITS/8-1:0] be,
    input  logic [ADDR_BITS-1:0]   addr_write,
    input  logic [DATA_BITS-1:0]   data_write,
    input  logic                   re,
    input  logic [ADDR_BITS-1:0]   addr_read,
    output logic [DATA_BITS-1:0]   data_read,
    output logic                   read_valid
);

    localparam int                 DEPTH     = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   cnt_q, cnt_d;
    logic [DATA_BITS-1:0]   data_read_q, data_read_d;
    logic                   read_valid_q, read_valid_d;
    logic [DATA_BITS-1:0]   mem_q [DEPTH];

    logic                   mem_wr_en;
    logic [ADDR_BITS-1:0]   mem_wr_addr;
    logic [DATA_BITS-1:0]   mem_wr_data;
    logic [DATA_BITS-1:0]   merged_word;
    logic                   user_wr;
    logic                   rd_en;

    // The same merged word feeds the array write and, on an address match,
    // the forwarded read result.
    byte_merge #(
        .DATA_BITS (DATA_BITS)
    ) u_byte_merge (
        .old_word (mem_q[addr_write]),
        .new_word (data_write),
        .be       (be),
        .merged   (merged_word)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        data_read_d  = data_read_q;
        read_valid_d = 1'b0;
        mem_wr_en    = 1'b0;
        mem_wr_addr  = addr_write;
        mem_wr_data  = merged_word;
        user_wr      = 1'b0;
        rd_en        = 1'b0;

        case (state_q)
            CLEAR: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = cnt_q;
                mem_wr_data = '0;
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                end else begin
                    cnt_d = cnt_q + ADDR_BITS'(1);
                end
            end
            READY: begin
                rd_en = re;
                if (clear) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    user_wr   = we;
                    mem_wr_en = we;
                end
            end
            default: state_d = CLEAR;
        endcase

        if (rd_en) begin
            read_valid_d = 1'b1;
            if (BYPASS != 0 && user_wr && addr_write == addr_read) begin
                data_read_d = merged_word;
            end else begin
                data_read_d = mem_q[addr_read];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= CLEAR;
            cnt_q        <= '0;
            data_read_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_read_q  <= data_read_d;
            read_valid_q <= read_valid_d;
        end
    end

    // NOTE: the array has no reset so it maps onto RAM macros; its contents
    // are zeroed by the sweep instead.
    always_ff @(posedge clock) begin
        if (mem_wr_en) begin
            mem_q[mem_wr_addr] <= mem_wr_data;
        end
    end

    assign busy       = (state_q == CLEAR);
    assign data_read  = data_read_q;
    assign read_valid = read_valid_q;

endmodule

// File: tb/tb_param_ram.sv
// Directed bench for param_ram (ADDR_BITS=4): one write-first and one
// read-old-data instance driven by identical stimulus.
module tb_param_ram;

    logic        clock;
    logic        reset_n;
    logic        clear;
    logic        we;
    logic [3:0]  be;
    logic [3:0]  addr_write;
    logic [31:0] data_write;
    logic        re;
    logic [3:0]  addr_read;

    logic        busy1, busy0;
    logic [31:0] data_read1, data_read0;
    logic        read_valid1, read_valid0;

    int n_checks = 0;
    int n_fail   = 0;

    param_ram #(.ADDR_BITS(4), .DATA_BITS(32), .BYPASS(1)) dut_bp1 (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (clear),
        .busy       (busy1),
        .we         (we),
        .be         (be),
        .addr_write (addr_write),
        .data_write (data_write),
        .re         (re),
        .addr_read  (addr_read),
        .data_read  (data_read1),
        .read_valid (read_valid1)
    );

    param_ram #(.ADDR_BITS(4), .DATA_BITS(32), .BYPASS(0)) dut_bp0 (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (clear),
        .busy       (busy0),
        .we         (we),
        .be         (be),
        .addr_write (addr_write),
        .data_write (data_write),
        .re         (re),
        .addr_read  (addr_read),
        .data_read  (data_read0),
        .read_valid (read_valid0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [3:0]  aw;
        logic [31:0] dw;
        logic        re;
        logic [3:0]  ar;
        logic        exp_valid;
        logic [31:0] exp_d1;
        logic [31:0] exp_d0;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        clear      = 1'b0;
        we         = 1'b0;
        be         = 4'h0;
        addr_write = 4'h0;
        data_write = 32'h0;
        re         = 1'b0;
        addr_read  = 4'h0;
    endtask

    // Counts edges until busy drops on both instances, bounded.
    task automatic measure_sweep(input string name);
        int n;
        n = 0;
        while ((busy1 || busy0) && n < 100) begin
            step();
            n++;
        end
        check(name, 32'(n), 32'd16);
        check({name, "_idle1"}, {31'b0, busy1}, 32'd0);
        check({name, "_idle0"}, {31'b0, busy0}, 32'd0);
    endtask

    task automatic read_both(input logic [3:0] a, input logic [31:0] exp, input string name);
        re        = 1'b1;
        addr_read = a;
        step();
        re        = 1'b0;
        check({name, "_v1"}, {31'b0, read_valid1}, 32'd1);
        check({name, "_d1"}, data_read1, exp);
        check({name, "_v0"}, {31'b0, read_valid0}, 32'd1);
        check({name, "_d0"}, data_read0, exp);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'hF, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0, 32'h00000000, 32'h00000000};
        vecs[1]  = '{1'b1, 4'h1, 4'd3, 32'h000000AA, 1'b0, 4'd0, 1'b0, 32'h00000000, 32'h00000000};
        vecs[2]  = '{1'b0, 4'h0, 4'd0, 32'h00000000, 1'b1, 4'd3, 1'b1, 32'hDEADBEAA, 32'hDEADBEAA};
        vecs[3]  = '{1'b0, 4'h0, 4'd0, 32'h00000000, 1'b0, 4'd0, 1'b0, 32'hDEADBEAA, 32'hDEADBEAA};
        vecs[4]  = '{1'b1, 4'hF, 4'd5, 32'h12345678, 1'b1, 4'd5, 1'b1, 32'h12345678, 32'h00000000};
        vecs[5]  = '{1'b0, 4'h0, 4'd0, 32'h00000000, 1'b1, 4'd5, 1'b1, 32'h12345678, 32'h12345678};
        vecs[6]  = '{1'b1, 4'h0, 4'd5, 32'hFFFFFFFF, 1'b0, 4'd0, 1'b0, 32'h12345678, 32'h12345678};
        vecs[7]  = '{1'b0, 4'h0, 4'd0, 32'h00000000, 1'b1, 4'd5, 1'b1, 32'h12345678, 32'h12345678};
        vecs[8]  = '{1'b1, 4'h6, 4'd5, 32'hAABBCCDD, 1'b1, 4'd5, 1'b1, 32'h12BBCC78, 32'h12345678};
        vecs[9]  = '{1'b0, 4'h0, 4'd0, 32'h00000000, 1'b1, 4'd5, 1'b1, 32'h12BBCC78, 32'h12BBCC78};
        vecs[10] = '{1'b1, 4'hF, 4'd7, 32'h11111111, 1'b1, 4'd3, 1'b1, 32'hDEADBEAA, 32'hDEADBEAA};

        // Reset state
        idle_inputs();
        reset_n = 1'b0;
        #12;
        check("rst_busy1", {31'b0, busy1}, 32'd1);
        check("rst_busy0", {31'b0, busy0}, 32'd1);
        check("rst_data1", data_read1, 32'h0);
        check("rst_valid1", {31'b0, read_valid1}, 32'd0);
        check("rst_data0", data_read0, 32'h0);
        check("rst_valid0", {31'b0, read_valid0}, 32'd0);
        step();
        reset_n = 1'b1;
        measure_sweep("init_sweep");

        for (int a = 0; a < 16; a++) begin
            read_both(4'(a), 32'h0, $sformatf("zero_rd%0d", a));
        end

        // Table-driven write/read/bypass vectors
        for (int i = 0; i < 11; i++) begin
            we         = vecs[i].we;
            be         = vecs[i].be;
            addr_write = vecs[i].aw;
            data_write = vecs[i].dw;
            re         = vecs[i].re;
            addr_read  = vecs[i].ar;
            step();
            check($sformatf("vec%0d_v1", i), {31'b0, read_valid1}, {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d_d1", i), data_read1, vecs[i].exp_d1);
            check($sformatf("vec%0d_v0", i), {31'b0, read_valid0}, {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d_d0", i), data_read0, vecs[i].exp_d0);
        end
        idle_inputs();
        read_both(4'd7, 32'h11111111, "rd_addr7");

        // Clear wins over a simultaneous write
        clear      = 1'b1;
        we         = 1'b1;
        be         = 4'hF;
        addr_write = 4'd2;
        data_write = 32'hFFFFFFFF;
        step();
        idle_inputs();
        check("clr_busy1", {31'b0, busy1}, 32'd1);
        measure_sweep("clr_sweep");
        read_both(4'd2, 32'h0, "clr_addr2");
        read_both(4'd3, 32'h0, "clr_addr3");

        // Accesses while busy are ignored; clear while busy does not restart
        clear = 1'b1;
        step();
        begin
            int vcount;
            vcount     = 0;
            we         = 1'b1;
            be         = 4'hF;
            addr_write = 4'd4;
            data_write = 32'hCAFEF00D;
            re         = 1'b1;
            addr_read  = 4'd4;
            for (int k = 0; k < 15; k++) begin
                step();
                if (read_valid1 || read_valid0) vcount++;
            end
            clear = 1'b0;
            check("busy_no_valid", 32'(vcount), 32'd0);
            check("busy_hold_d1", data_read1, 32'h0);
            step();
            idle_inputs();
            check("busy_sweep_done", {31'b0, busy1}, 32'd0);
        end
        read_both(4'd4, 32'h0, "busy_addr4");

        // Reset mid-sweep at address 7
        we         = 1'b1;
        be         = 4'hF;
        addr_write = 4'd9;
        data_write = 32'h00000055;
        step();
        idle_inputs();
        read_both(4'd9, 32'h00000055, "pre_rst_addr9");
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int k = 0; k < 7; k++) step();
        check("mid_busy", {31'b0, busy1}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, busy1}, 32'd1);
        check("mid_rst_data1", data_read1, 32'h0);
        check("mid_rst_data0", data_read0, 32'h0);
        check("mid_rst_valid", {31'b0, read_valid1}, 32'd0);
        step();
        step();
        reset_n = 1'b1;
        measure_sweep("restart_sweep");
        read_both(4'd9, 32'h0, "post_rst_addr9");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/param_ram.md
PARAM_RAM -- requirements
Module: param_ram

Interface
REQ-001 The block SHALL expose parameter ADDR_BITS, default 8, which sets the address width; depth is 2**ADDR_BITS words.
REQ-002 The block SHALL expose parameter DATA_BITS, default 32, which sets the word width and SHALL be a multiple of 8.
REQ-003 The block SHALL expose parameter BYPASS, default 1: 1 = write-first forwarding, 0 = read-old-data.
REQ-004 Port clock: input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset_n: input, 1 bit, asynchronous active-low reset.
REQ-006 Port clear: input, 1 bit, request to zero the whole array.
REQ-007 Port busy: output, 1 bit, high while the clear sweep is running.
REQ-008 Port we: input, 1 bit, write strobe.
REQ-009 Port be: input, DATA_BITS/8 bits, byte enables for the write.
REQ-010 Port addr_write: input, ADDR_BITS bits, write address.
REQ-011 Port data_write: input, DATA_BITS bits, write data.
REQ-012 Port re: input, 1 bit, read strobe.
REQ-013 Port addr_read: input, ADDR_BITS bits, read address.
REQ-014 Port data_read: output, DATA_BITS bits, registered read data.
REQ-015 Port read_valid: output, 1 bit, one-cycle pulse qualifying data_read.

Function
REQ-016 The FSM SHALL have exactly two states, CLEAR and READY.
REQ-017 In CLEAR, the block SHALL write zero to one address per cycle, counting from 0 up to 2**ADDR_BITS-1, then enter READY on the following edge; busy SHALL be 1 throughout CLEAR.
REQ-018 A full sweep SHALL take exactly 2**ADDR_BITS cycles.
REQ-019 In READY, clear=1 SHALL move the block to CLEAR with the counter at 0 on the next edge.
REQ-020 Clear SHALL be ignored while the block is already in CLEAR.
REQ-021 In READY, we=1 SHALL update only the bytes whose be bit is 1 at addr_write; be=0 SHALL be a no-op.
REQ-022 In READY, re=1 SHALL load data_read with the word at addr_read on the next edge and set read_valid=1 for that one cycle (latency 1).
REQ-023 With re=0, data_read SHALL hold its last value and read_valid SHALL be 0.
REQ-024 For a read and write to the same address in the same cycle with BYPASS=1, data_read SHALL return the stored word merged byte-wise with data_write under be.
REQ-025 For the same case with BYPASS=0, data_read SHALL return the pre-write word.
REQ-026 While busy, we and re SHALL be ignored: no array change and no read_valid.
REQ-027 If clear and we are both asserted in READY, clear SHALL win and the write SHALL be dropped.
REQ-028 The sweep counter SHALL stop at the last address and SHALL NOT wrap.

Reset
REQ-029 Asserting reset_n low SHALL immediately force state=CLEAR, counter=0, busy=1, data_read=0, read_valid=0.
REQ-030 The array SHALL NOT be asynchronously reset; it SHALL be zeroed by the sweep after reset release.
REQ-031 Reset asserted mid-sweep or mid-access SHALL restart the sweep from address 0.

Structure
REQ-032 The ADDR_BITS and DATA_BITS defaults and the state enum (CLEAR, READY) SHALL live in the shared defines package.
REQ-033 The block SHALL be built as one module plus one sub-module, byte_merge, a combinational byte-enable merge that both the write path and the bypass path use.

Verification
REQ-034 Release reset, ADDR_BITS=4 -> busy=1 for exactly 16 cycles, then 0; reading all 16 addresses returns 0.
REQ-035 Write 0xDEADBEEF to addr 3 with be=4'b1111, then write 0x000000AA with be=4'b0001, then read addr 3 -> data_read=0xDEADBEAA with read_valid pulsed for 1 cycle.
REQ-036 Simultaneous write of 0x12345678 and read of addr 5 that holds 0 -> data_read=0x12345678 with BYPASS=1, or 0 with BYPASS=0.
REQ-037 Assert clear and a write of 0xFFFFFFFF to addr 2 in the same READY cycle -> write dropped; after the sweep, addr 2 reads 0.
REQ-038 Assert reset_n low at sweep address 7 -> outputs take their reset values at once; after release the sweep restarts at 0 and lasts the full depth.
REQ-039 Assert re and we while busy -> no read_valid and the array is unchanged after the sweep.
